// File: rtl/gate_bist_if.sv
// rtl/gate_bist_if.sv - control, result and gate-under-test signals of gate_bist_checker
interface gate_bist_if;
    logic       start;
    logic       dut_a;
    logic       dut_b;
    logic       dut_y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;

    // master: requester and gate under test; slave: the checker
    modport master (
        output start, dut_y,
        input  dut_a, dut_b, busy, done, pass, err_count, fail_vec
    );
    modport slave (
        input  start, dut_y,
        output dut_a, dut_b, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/gate_bist_checker.sv
// rtl/gate_bist_checker.sv - 4-vector 2-input gate BIST; `define GATE_BIST_STOP_ON_FAIL_EN ends the test at the first mismatch
module gate_bist_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  TRUTH_TABLE   = 4'b1000
) (
    input  logic        clk,
    input  logic        rst,
    gate_bist_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] err_q, err_d;
    logic [3:0] fail_q, fail_d;
    logic       pass_q, pass_d;
    logic       mismatch;
    logic       last_sample;

    assign mismatch = (bus.dut_y != TRUTH_TABLE[idx_q]);

`ifdef GATE_BIST_STOP_ON_FAIL_EN
    assign last_sample = (idx_q == 2'd3) || mismatch;
`else
    assign last_sample = (idx_q == 2'd3);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = WAIT;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                    err_d   = 3'd0;
                    fail_d  = 4'd0;
                    pass_d  = 1'b0;
                end
            end
            WAIT: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    // saturate defensively; four vectors cannot exceed 4
                    if (err_q < 3'd4) begin
                        err_d = err_q + 3'd1;
                    end
                    fail_d[idx_q] = 1'b1;
                end
                if (last_sample) begin
                    state_d = DONE;
                    pass_d  = (err_d == 3'd0);
                end else begin
                    state_d = WAIT;
                    idx_d   = idx_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // vector drive is gated so the gate inputs rest at 00 outside a run
    assign bus.busy      = (state_q == WAIT) || (state_q == SAMPLE);
    assign bus.done      = (state_q == DONE);
    assign bus.dut_a     = bus.busy & idx_q[1];
    assign bus.dut_b     = bus.busy & idx_q[0];
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fail_q;
endmodule

// File: tb/tb_gate_bist_checker.sv
// tb/tb_gate_bist_checker.sv - directed bench for gate_bist_checker with a cycle-indexed result model
module tb_gate_bist_checker;
    localparam int S = 2;
    localparam int P = S + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   mode0 = 0;
    int   mode1 = 1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gate_bist_if if0();
    gate_bist_if if1();

    gate_bist_checker #(.SETTLE_CYCLES(S), .TRUTH_TABLE(4'b1000)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    gate_bist_checker #(.SETTLE_CYCLES(S), .TRUTH_TABLE(4'b0110)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    // gate stand-ins: 0 AND, 1 XOR, 2 stuck-at-1, 3 stuck-at-0
    function automatic logic gate_y(int m, logic a, logic b);
        case (m)
            0:       return a & b;
            1:       return a ^ b;
            2:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign if0.start = start;
    assign if1.start = start;
    assign if0.dut_y = gate_y(mode0, if0.dut_a, if0.dut_b);
    assign if1.dut_y = gate_y(mode1, if1.dut_a, if1.dut_b);

    logic [11:0] out_v [2];
    assign out_v[0] = {if0.busy, if0.done, if0.pass, if0.dut_a, if0.dut_b, if0.err_count, if0.fail_vec};
    assign out_v[1] = {if1.busy, if1.done, if1.pass, if1.dut_a, if1.dut_b, if1.err_count, if1.fail_vec};

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // model: m_t = cycles since the accepting edge, -1 when idle
    int         m_t [2]   = '{-1, -1};
    int         m_end [2];
    int         start_cyc [2];
    logic [3:0] m_mis [2];
    int         f_err [2];
    logic [3:0] f_fail [2];
    logic       f_pass [2];
    int         h_err [2]  = '{0, 0};
    logic [3:0] h_fail [2] = '{4'd0, 4'd0};
    logic       h_pass [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_t[i] = -1;
                h_err[i] = 0;
                h_fail[i] = 4'd0;
                h_pass[i] = 1'b0;
            end else if (m_t[i] < 0) begin
                if (start) begin
                    logic [3:0] tt;
                    logic [3:0] mis;
                    int first;
                    tt = (i == 0) ? 4'b1000 : 4'b0110;
                    mis = 4'd0;
                    first = -1;
                    for (int k = 0; k < 4; k++) begin
                        mis[k] = gate_y((i == 0) ? mode0 : mode1, k[1], k[0]) != tt[k];
                    end
                    for (int k = 3; k >= 0; k--) begin
                        if (mis[k]) first = k;
                    end
`ifdef GATE_BIST_STOP_ON_FAIL_EN
                    if (first >= 0) begin
                        m_end[i] = (first + 1) * P;
                        f_fail[i] = 4'd1 << first;
                        f_err[i] = 1;
                    end else begin
                        m_end[i] = 4 * P;
                        f_fail[i] = 4'd0;
                        f_err[i] = 0;
                    end
                    m_mis[i] = f_fail[i];
`else
                    m_end[i] = 4 * P;
                    f_fail[i] = mis;
                    f_err[i] = $countones(mis);
                    m_mis[i] = mis;
`endif
                    f_pass[i] = (f_err[i] == 0);
                    m_t[i] = 0;
                    start_cyc[i] = cyc;
                    h_err[i] = 0;
                    h_fail[i] = 4'd0;
                    h_pass[i] = 1'b0;
                end
            end else if (m_t[i] == m_end[i]) begin
                m_t[i] = -1;
                h_err[i] = f_err[i];
                h_fail[i] = f_fail[i];
                h_pass[i] = f_pass[i];
            end else begin
                m_t[i]++;
            end
        end
    end

    int         done_at [2]  = '{-1, -1};
    int         done_cnt [2] = '{0, 0};

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < 2; i++) begin
                int         e_busy, e_done, e_pass, e_a, e_b, e_err, vec;
                logic [3:0] e_fail;
                logic [3:0] msk;
                if (m_t[i] < 0) begin
                    e_busy = 0; e_done = 0; e_a = 0; e_b = 0;
                    e_err = h_err[i]; e_fail = h_fail[i]; e_pass = h_pass[i];
                end else if (m_t[i] < m_end[i]) begin
                    vec = m_t[i] / P;
                    msk = 4'((1 << vec) - 1);
                    e_busy = 1; e_done = 0; e_a = vec / 2; e_b = vec % 2;
                    e_fail = m_mis[i] & msk; e_err = $countones(e_fail); e_pass = 0;
                end else begin
                    e_busy = 0; e_done = 1; e_a = 0; e_b = 0;
                    e_err = f_err[i]; e_fail = f_fail[i]; e_pass = f_pass[i];
                end
                chk($sformatf("i%0d_busy@%0d", i, cyc), out_v[i][11], e_busy);
                chk($sformatf("i%0d_done@%0d", i, cyc), out_v[i][10], e_done);
                chk($sformatf("i%0d_pass@%0d", i, cyc), out_v[i][9], e_pass);
                chk($sformatf("i%0d_dut_a@%0d", i, cyc), out_v[i][8], e_a);
                chk($sformatf("i%0d_dut_b@%0d", i, cyc), out_v[i][7], e_b);
                chk($sformatf("i%0d_err@%0d", i, cyc), out_v[i][6:4], e_err);
                chk($sformatf("i%0d_fail_vec@%0d", i, cyc), out_v[i][3:0], e_fail);
                if (out_v[i][10]) begin
                    done_at[i] = cyc - start_cyc[i];
                    done_cnt[i]++;
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int k;
        for (k = 0; k < 200; k++) begin
            if (m_t[0] < 0 && m_t[1] < 0 && !if0.busy && !if1.busy && !if0.done && !if1.done) break;
            @(negedge clk);
        end
        chk({name, "_timeout"}, (k < 200) ? 1 : 0, 1);
    endtask

    initial begin
        int d0, d1;
        mode0 = 0;
        mode1 = 1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_outputs_i0", int'(out_v[0]), 0);
        chk("reset_outputs_i1", int'(out_v[1]), 0);

        // ideal AND and XOR gates
        d0 = done_cnt[0]; d1 = done_cnt[1];
        pulse_start();
        wait_idle("and_run");
        chk("and_done_pulses", done_cnt[0] - d0, 1);
        chk("xor_done_pulses", done_cnt[1] - d1, 1);
        chk("and_done_at", done_at[0], 12);
        chk("and_pass", int'(if0.pass), 1);
        chk("and_err", int'(if0.err_count), 0);
        chk("and_fail_vec", int'(if0.fail_vec), 0);
        chk("xor_pass", int'(if1.pass), 1);

        // stuck-at faults
        mode0 = 2;
        mode1 = 3;
        d0 = done_cnt[0];
        pulse_start();
        wait_idle("stuck_run");
        chk("stuck1_done_pulses", done_cnt[0] - d0, 1);
        chk("stuck1_pass", int'(if0.pass), 0);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        chk("stuck1_done_at", done_at[0], 3);
        chk("stuck1_err", int'(if0.err_count), 1);
        chk("stuck1_fail_vec", int'(if0.fail_vec), 4'b0001);
        chk("stuck0_xor_fail_vec", int'(if1.fail_vec), 4'b0010);
`else
        chk("stuck1_done_at", done_at[0], 12);
        chk("stuck1_err", int'(if0.err_count), 3);
        chk("stuck1_fail_vec", int'(if0.fail_vec), 4'b0111);
        chk("stuck0_xor_fail_vec", int'(if1.fail_vec), 4'b0110);
`endif
        repeat (5) @(negedge clk);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        chk("stuck1_err_held", int'(if0.err_count), 1);
`else
        chk("stuck1_err_held", int'(if0.err_count), 3);
`endif

        // reset sampled at N+5 mid-run, then a clean rerun
        mode0 = 0;
        mode1 = 1;
        pulse_start();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_outputs_i0", int'(out_v[0]), 0);
        chk("midrst_outputs_i1", int'(out_v[1]), 0);
        pulse_start();
        wait_idle("after_rst_run");
        chk("after_rst_done_at", done_at[0], 12);
        chk("after_rst_pass", int'(if0.pass), 1);

        // reset and start on the same edge
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", int'(if0.busy), 0);
        chk("rst_start_pass_cleared", int'(if0.pass), 0);
        repeat (2) @(negedge clk);

        // second start at N+4 is ignored
        d0 = done_cnt[0];
        pulse_start();
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("repulse_run");
        chk("repulse_done_pulses", done_cnt[0] - d0, 1);
        chk("repulse_done_at", done_at[0], 12);
        chk("repulse_pass", int'(if0.pass), 1);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/gate_bist_checker.md
GATE_BIST_CHECKER -- requirements
Module: gate_bist_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: cycles each input vector is held before the output is sampled; legal range 1..15.
REQ-002 Parameter TRUTH_TABLE, default 4'b1000: expected gate output, where bit k is the expected output for vector k = {a,b}; the default is AND.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  one-cycle request to run the 4-vector test.
REQ-006 dut_a  output  1  gate-under-test input a; equals vector index bit 1.
REQ-007 dut_b  output  1  gate-under-test input b; equals vector index bit 0.
REQ-008 dut_y  input  1  gate-under-test output.
REQ-009 busy  output  1  high from the cycle after start is accepted through the last SAMPLE cycle.
REQ-010 done  output  1  one-cycle pulse when the test completes.
REQ-011 pass  output  1  test result; valid from done until the next accepted start.
REQ-012 err_count  output  3  number of mismatching vectors, 0..4.
REQ-013 fail_vec  output  4  bit k set when vector k mismatched.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, SAMPLE and DONE.
REQ-015 In IDLE with start=1 at edge N, the block SHALL enter WAIT with idx=0, dut_a=0, dut_b=0, settle counter=0, err_count=0, fail_vec=0 and pass=0.
REQ-016 The block SHALL ignore start in every state other than IDLE.
REQ-017 WAIT SHALL last exactly SETTLE_CYCLES cycles, with dut_a and dut_b held stable, and then go to SAMPLE.
REQ-018 SAMPLE SHALL last one cycle and compare dut_y with TRUTH_TABLE[idx]; on mismatch, err_count SHALL increment and fail_vec[idx] SHALL be set at the same edge.
REQ-019 From SAMPLE with idx<3, the block SHALL increment idx, update dut_a and dut_b, and re-enter WAIT; with idx=3 it SHALL go to DONE.
REQ-020 Vector k's WAIT SHALL start at edge N+k*(SETTLE_CYCLES+1), and DONE SHALL start at edge N+4*(SETTLE_CYCLES+1), which is N+12 at the default SETTLE_CYCLES.
REQ-021 In DONE, done=1 and pass=(err_count==0) for exactly one cycle; the block SHALL then return to IDLE.
REQ-022 pass, err_count and fail_vec SHALL hold their values in IDLE until the next accepted start.
REQ-023 dut_a and dut_b SHALL return to 0 in DONE and IDLE.
REQ-024 err_count SHALL NOT wrap; 4 is the maximum value reachable.

Reset
REQ-025 rst=1 at any edge, including mid-test, SHALL force IDLE with idx=0, counter=0, dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_count=0 and fail_vec=0.
REQ-026 If rst and start are both high at the same edge, rst SHALL win and start SHALL be discarded.

Configuration
REQ-027 The macro GATE_BIST_STOP_ON_FAIL_EN SHALL control stop-on-fail behaviour.
REQ-028 When GATE_BIST_STOP_ON_FAIL_EN is defined, the first mismatch in SAMPLE SHALL go directly to DONE; this gives err_count=1, a one-hot fail_vec and pass=0.
REQ-029 When GATE_BIST_STOP_ON_FAIL_EN is undefined, all 4 vectors SHALL always be applied and errors accumulated.

Verification
REQ-030 Default parameters, ideal AND DUT, start at edge N -> dut_{a,b} sequence 00,01,10,11, each held 3 cycles; done at N+12; pass=1, err_count=0, fail_vec=0000.
REQ-031 DUT output stuck at 1, macro undefined -> done at N+12, pass=0, err_count=3, fail_vec=0111.
REQ-032 DUT output stuck at 1, GATE_BIST_STOP_ON_FAIL_EN defined -> done at N+3, err_count=1, fail_vec=0001, and dut_{a,b} never reaches 01.
REQ-033 rst asserted at N+5 during a run -> all outputs 0 at the following cycle; a new start then completes normally.
REQ-034 start re-pulsed at N+4 -> ignored, with done still at N+12; TRUTH_TABLE=4'b0110 with an XOR DUT -> pass=1.
